// File: rtl/winchk_pkg.sv
// Shared constants and helpers for the multi-channel timing-window checker.
// Optional first-fail capture is enabled by defining WINCHK_FIRST_FAIL_EN.
package winchk_pkg;

  // Default width of the aggregate pass/fail counters.
  localparam int CNT_W_DEF = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Add inc to cur, clamping at 2^w-1 (w is 1..32).
  function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, cur} + {1'b0, inc};
    max = (w >= 32) ? 33'h0_ffff_ffff : ((33'd1 << w) - 33'd1);
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

  // Number of set bits in a channel vector (up to 32 channels).
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/winchk_chan.sv
// One checker channel: pending-attempt shift register indexed by age,
// window satisfaction / expiry decision and registered pass/fail pulses.
// pass_evt/fail_evt are the combinational decisions of the current cycle,
// exported so the top can count and capture them alongside the pulses.
module winchk_chan
  import winchk_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic trig,
  input  logic resp,
  output logic pass_evt,
  output logic fail_evt,
  output logic pass,
  output logic fail
);

  // pend[k] = an attempt of age k is outstanding; age 0 is trig&en itself.
  logic [MAX_DLY:1] pend;
  logic [MAX_DLY:1] pend_n;
  logic [MAX_DLY:0] att;
  logic [MAX_DLY:0] win;
  logic [MAX_DLY:0] hit;

  // Ages that a resp is allowed to satisfy.
  always_comb begin
    win = '0;
    for (int k = 0; k <= MAX_DLY; k++) win[k] = (k >= MIN_DLY);
  end

  assign att      = {pend, trig & en};
  // A single resp satisfies every in-window attempt at once.
  assign hit      = att & win & {(MAX_DLY + 1){resp}};
  assign pass_evt = |hit;
  // Oldest attempt expires only without resp; resp at MAX_DLY always hits.
  assign fail_evt = att[MAX_DLY] & ~resp;

  // Survivors age by one; the oldest slot drops off either way.
  always_comb begin
    pend_n = '0;
    for (int k = 1; k <= MAX_DLY; k++) pend_n[k] = att[k-1] & ~hit[k-1];
  end

  // State and pulse registers; clr drops the decisions made this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (clr) begin
      pend <= '0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      pend <= pend_n;
      pass <= pass_evt;
      fail <= fail_evt;
    end
  end

endmodule

// File: rtl/winchk_multi.sv
// N-channel timing-window checker: trig |-> ##[MIN_DLY:MAX_DLY] resp per
// channel with overlapping attempts, saturating pass/fail counters and a
// sticky error flag. Define WINCHK_FIRST_FAIL_EN to add first-fail capture
// (ff_valid/ff_chan/ff_time) driven by a free-running cycle counter.
module winchk_multi
  import winchk_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int CH_W   = chan_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [N_CH-1:0]  trig,
  input  logic [N_CH-1:0]  resp,
  output logic [N_CH-1:0]  pass,
  output logic [N_CH-1:0]  fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky
`ifdef WINCHK_FIRST_FAIL_EN
  ,
  output logic             ff_valid,
  output logic [CH_W-1:0]  ff_chan,
  output logic [31:0]      ff_time
`endif
);

  if (MAX_DLY < 1 || MIN_DLY < 0 || MIN_DLY > MAX_DLY ||
      N_CH < 1 || N_CH > 32 || CNT_W < 1 || CNT_W > 32) begin : g_bad_cfg
    $error("winchk_multi: illegal parameter combination");
  end

  logic [N_CH-1:0] pass_evt;
  logic [N_CH-1:0] fail_evt;
  logic [31:0]     pass_sum;
  logic [31:0]     fail_sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    winchk_chan #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .trig     (trig[i]),
      .resp     (resp[i]),
      .pass_evt (pass_evt[i]),
      .fail_evt (fail_evt[i]),
      .pass     (pass[i]),
      .fail     (fail[i])
    );
  end

  // Counters advance by the number of channels reporting, not attempts.
  assign pass_sum = sat_add(32'(pass_cnt), 32'(popcount(32'(pass_evt))), CNT_W);
  assign fail_sum = sat_add(32'(fail_cnt), 32'(popcount(32'(fail_evt))), CNT_W);

  // Aggregate counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      pass_cnt   <= pass_sum[CNT_W-1:0];
      fail_cnt   <= fail_sum[CNT_W-1:0];
      err_sticky <= err_sticky | (|fail_evt);
    end
  end

`ifdef WINCHK_FIRST_FAIL_EN
  logic [31:0]     cyc;
  logic [CH_W-1:0] ff_idx;

  // Lowest-indexed channel failing in the current cycle.
  always_comb begin
    ff_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (fail_evt[i]) ff_idx = CH_W'(i);
  end

  // Free-running cycle counter; only reset restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  // Capture the first fail after reset/clr; later fails never overwrite.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ff_valid <= 1'b0;
      ff_chan  <= '0;
      ff_time  <= '0;
    end else if (!ff_valid && (|fail_evt)) begin
      ff_valid <= 1'b1;
      ff_chan  <= ff_idx;
      ff_time  <= cyc;
    end
  end
`endif

endmodule

// File: tb/tb_winchk_multi.sv
// Bench for winchk_multi (N_CH=4, MIN_DLY=1, MAX_DLY=3, CNT_W=8).
// Model: per-channel queues of trigger times, resolved by age each cycle.
// Compiles with or without WINCHK_FIRST_FAIL_EN.
module tb_winchk_multi;

  localparam int NC  = 4;
  localparam int MIN = 1;
  localparam int MAX = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [NC-1:0] trig = '0;
  logic [NC-1:0] resp = '0;
  logic [NC-1:0] pass;
  logic [NC-1:0] fail;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic          err_sticky;
`ifdef WINCHK_FIRST_FAIL_EN
  logic          ff_valid;
  logic [1:0]    ff_chan;
  logic [31:0]   ff_time;
`endif

  winchk_multi #(.N_CH(NC), .MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .trig       (trig),
    .resp       (resp),
    .pass       (pass),
    .fail       (fail),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .err_sticky (err_sticky)
`ifdef WINCHK_FIRST_FAIL_EN
    ,
    .ff_valid   (ff_valid),
    .ff_chan    (ff_chan),
    .ff_time    (ff_time)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  int            tq[NC][$];   // trigger times of outstanding attempts
  int            tnow = 0;
  int            cyc_m = 0;
  logic [NC-1:0] exp_pass = '0;
  logic [NC-1:0] exp_fail = '0;
  int            exp_pcnt = 0;
  int            exp_fcnt = 0;
  logic          exp_sticky = 1'b0;
  logic          exp_ffv = 1'b0;
  int            exp_ffc = 0;
  int            exp_fft = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model of one clock edge with the given inputs.
  task automatic model_step(input logic rn, input logic c, input logic e,
                            input logic [NC-1:0] tg, input logic [NC-1:0] rs);
    logic [NC-1:0] p, f;
    int keep[$];
    int age;
    if (!rn) begin
      for (int ch = 0; ch < NC; ch++) tq[ch].delete();
      exp_pass = '0; exp_fail = '0; exp_pcnt = 0; exp_fcnt = 0;
      exp_sticky = 1'b0; exp_ffv = 1'b0; exp_ffc = 0; exp_fft = 0;
      cyc_m = 0;
      tnow++;
      return;
    end
    p = '0; f = '0;
    for (int ch = 0; ch < NC; ch++) begin
      if (tg[ch] && e) tq[ch].push_back(tnow);
      keep.delete();
      foreach (tq[ch][i]) begin
        age = tnow - tq[ch][i];
        if (rs[ch] && age >= MIN && age <= MAX) p[ch] = 1'b1;
        else if (age >= MAX) f[ch] = 1'b1;
        else keep.push_back(tq[ch][i]);
      end
      tq[ch] = keep;
    end
    if (c) begin
      for (int ch = 0; ch < NC; ch++) tq[ch].delete();
      exp_pass = '0; exp_fail = '0; exp_pcnt = 0; exp_fcnt = 0;
      exp_sticky = 1'b0; exp_ffv = 1'b0; exp_ffc = 0; exp_fft = 0;
    end else begin
      exp_pass = p;
      exp_fail = f;
      exp_pcnt = exp_pcnt + $countones(p);
      if (exp_pcnt > 255) exp_pcnt = 255;
      exp_fcnt = exp_fcnt + $countones(f);
      if (exp_fcnt > 255) exp_fcnt = 255;
      if (f != 0) exp_sticky = 1'b1;
      if (!exp_ffv && f != 0) begin
        exp_ffv = 1'b1;
        exp_fft = cyc_m;
        for (int ch = NC - 1; ch >= 0; ch--) if (f[ch]) exp_ffc = ch;
      end
    end
    cyc_m++;
    tnow++;
  endtask

  // Driver: apply inputs on the falling edge, return just after the rising edge.
  task automatic step(input logic rn, input logic c, input logic e,
                      input logic [NC-1:0] tg, input logic [NC-1:0] rs);
    @(negedge clk);
    rst_n = rn; clr = c; en = e; trig = tg; resp = rs;
    model_step(rn, c, e, tg, rs);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      chk("pass", pass, exp_pass);
      chk("fail", fail, exp_fail);
      chk("pass_cnt", pass_cnt, exp_pcnt);
      chk("fail_cnt", fail_cnt, exp_fcnt);
      chk("err_sticky", err_sticky, exp_sticky);
`ifdef WINCHK_FIRST_FAIL_EN
      chk("ff_valid", ff_valid, exp_ffv);
      chk("ff_chan", ff_chan, exp_ffc);
      chk("ff_time", ff_time, exp_fft);
`endif
    end
  end

  initial begin
    chk_on = 1'b1;
    do_reset();
    chk("reset_pass_cnt", pass_cnt, 0);
    chk("reset_sticky", err_sticky, 0);

    // Directed: channels 0..3 from cycle 0 after reset.
    step(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0100);  // cycle 0
    step(1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000);  // cycle 1
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0001);  // cycle 2
    chk("lit_pass_c3", pass, 4'b0001);
    chk("lit_fail_c3", fail, 4'b0000);
    chk("lit_pcnt_c3", pass_cnt, 1);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b1000);  // cycle 3
    chk("lit_pass_c4", pass, 4'b1000);
    chk("lit_fail_c4", fail, 4'b0110);
    chk("lit_pcnt_c4", pass_cnt, 2);
    chk("lit_fcnt_c4", fail_cnt, 2);
    chk("lit_sticky_c4", err_sticky, 1);
`ifdef WINCHK_FIRST_FAIL_EN
    chk("lit_ff_chan", ff_chan, 1);
    chk("lit_ff_time", ff_time, 3);
`endif
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("lit_pulse_gone", {pass, fail}, 0);

    // Saturation: all channels pass every cycle, 300 passes in total.
    do_reset();
    for (int i = 0; i < 76; i++)
      step(1'b1, 1'b0, 1'b1, (i < 75) ? 4'b1111 : 4'b0000, (i > 0) ? 4'b1111 : 4'b0000);
    chk("lit_pcnt_sat", pass_cnt, 255);
    chk("lit_fcnt_sat", fail_cnt, 0);

    // Reset mid-window discards the attempt silently.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("lit_rst_fcnt", fail_cnt, 0);
    chk("lit_rst_sticky", err_sticky, 0);

    // clr mid-window (with prior counts) discards everything.
    step(1'b1, 1'b0, 1'b1, 4'b0011, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0001);
    step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("lit_clr_pcnt", pass_cnt, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("lit_clr_fcnt", fail_cnt, 0);
    chk("lit_clr_sticky", err_sticky, 0);

    // en=0: triggers ignored, no events at all.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000);
    chk("lit_en0_fcnt", fail_cnt, 0);

    // Randomized traffic with occasional clr, reset and en=0.
    for (int i = 0; i < 3000; i++) begin
      logic rn, c, e;
      rn = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 9) != 0);
      step(rn, c, e, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
